// File: rtl/bus_responder_pkg.sv
// Shared decode constants for the CPU byte-bus target endpoint.
package bus_responder_pkg;

    localparam logic [1:0] IO_BASE     = 2'b11;
    localparam logic [2:0] IO_UART_OFS = 3'd0;
    localparam logic [2:0] IO_CLK_OFS  = 3'd4;
    localparam int         RAM_ADDR_W  = 17;
    localparam int         BYTE_W      = 8;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with wrap-bit pointers and first-word fall-through output.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo
    import bus_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [BYTE_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Advance read/write pointers on accepted pops/pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/bus_responder.sv
// Target-side endpoint of the CPU byte bus: RAM port plus memory-mapped
// UART FIFOs, free-running cycle counter with snapshot, and stop flag.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int FULL_MARGIN   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic [31:0]           bus_a,
    input  logic                  bus_wr,
    input  logic [BYTE_W-1:0]     bus_din,
    output logic [BYTE_W-1:0]     bus_dout,
    output logic                  io_buffer_full,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic                  ram_we,
    output logic [BYTE_W-1:0]     ram_wdata,
    input  logic [BYTE_W-1:0]     ram_rdata,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  program_stop,
    output logic                  tx_overflow
);

    localparam int             TXW       = TX_DEPTH_LOG2 + 1;
    localparam logic [TXW-1:0] TX_DEPTH  = TXW'(2 ** TX_DEPTH_LOG2);
    localparam logic [TXW-1:0] TX_MARGIN = TXW'(FULL_MARGIN);

    logic                   is_io;
    logic [2:0]             ofs;
    logic                   io_wr;
    logic                   io_rd;
    logic                   tx_push;
    logic                   tx_push_ok;
    logic                   tx_pop;
    logic [BYTE_W-1:0]      tx_din;
    logic                   tx_empty;
    logic                   tx_full;
    logic [TXW-1:0]         tx_count;
    logic [TXW-1:0]         tx_next;
    logic [TXW-1:0]         tx_free;
    logic                   rx_pop;
    logic [BYTE_W-1:0]      rx_dout;
    logic                   rx_empty;
    logic                   rx_full_unused;
    logic [RX_DEPTH_LOG2:0] rx_count_unused;
    logic                   addr_hi_unused;
    logic [31:0]            cycle_cnt;
    logic [31:0]            snapshot;
    logic [BYTE_W-1:0]      io_rdata;
    logic                   rd_pending;
    logic                   rd_sel_ram;
    logic [BYTE_W-1:0]      io_byte;
    logic [BYTE_W-1:0]      dout_hold;

    assign addr_hi_unused = ^bus_a[31:18];

    assign is_io = (bus_a[17:16] == IO_BASE);
    assign ofs   = bus_a[2:0];
    assign io_wr = rdy_in & is_io & bus_wr;
    assign io_rd = rdy_in & is_io & ~bus_wr;

    assign ram_a     = bus_a[RAM_ADDR_W-1:0];
    assign ram_we    = rdy_in & bus_wr & ~is_io;
    assign ram_wdata = bus_din;

    // TX side: data writes push non-zero bytes, the stop register pushes 0x00.
    assign tx_push    = io_wr & (((ofs == IO_UART_OFS) && (bus_din != '0)) ||
                                  (ofs == IO_CLK_OFS));
    assign tx_din     = (ofs == IO_CLK_OFS) ? '0 : bus_din;
    assign tx_valid   = ~tx_empty;
    assign tx_pop     = tx_valid & tx_ready;
    assign tx_push_ok = tx_push & (~tx_full | tx_pop);
    assign tx_next    = tx_count + TXW'(tx_push_ok) - TXW'(tx_pop);
    assign tx_free    = TX_DEPTH - tx_next;

    assign rx_pop = io_rd & (ofs == IO_UART_OFS) & ~rx_empty;

    byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (tx_push),
        .din   (tx_din),
        .pop   (tx_pop),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full_unused),
        .count (rx_count_unused)
    );

    // Sticky status flags and the registered near-full indication.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            program_stop   <= 1'b0;
            tx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            if (io_wr && (ofs == IO_CLK_OFS)) program_stop <= 1'b1;
            if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
            io_buffer_full <= (tx_free <= TX_MARGIN);
        end
    end

    // Free-running cycle counter; a read of the low byte captures all 32 bits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cycle_cnt <= '0;
            snapshot  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (io_rd && (ofs == IO_CLK_OFS)) snapshot <= cycle_cnt;
        end
    end

    // I/O read data selection for the current bus address.
    always_comb begin
        io_rdata = '0;
        case (ofs)
            IO_UART_OFS: io_rdata = rx_empty ? '0 : rx_dout;
            IO_CLK_OFS:  io_rdata = cycle_cnt[7:0];
            3'd5:        io_rdata = snapshot[15:8];
            3'd6:        io_rdata = snapshot[23:16];
            3'd7:        io_rdata = snapshot[31:24];
            default:     io_rdata = '0;
        endcase
    end

    // Read pipeline: source selector and io byte registered for one cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_pending <= 1'b0;
            rd_sel_ram <= 1'b0;
            io_byte    <= '0;
            dout_hold  <= '0;
        end else begin
            dout_hold  <= bus_dout;
            rd_pending <= rdy_in & ~bus_wr;
            if (rdy_in && !bus_wr) begin
                rd_sel_ram <= ~is_io;
                io_byte    <= io_rdata;
            end
        end
    end

    // RAM data is only valid in the cycle after the read, so a hold register
    // keeps bus_dout stable through write and idle cycles.
    always_comb begin
        if (!rd_pending)     bus_dout = dout_hold;
        else if (rd_sel_ram) bus_dout = ram_rdata;
        else                 bus_dout = io_byte;
    end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder with randomized stimulus and a
// queue-based reference model of the FIFOs, counter and read path.
module tb_bus_responder;

    localparam int TXD    = 16;
    localparam int RXD    = 16;
    localparam int MARGIN = 2;
    localparam logic [31:0] A_UART = 32'h0003_0000;
    localparam logic [31:0] A_CLK  = 32'h0003_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] bus_a = '0;
    logic        bus_wr = 1'b0;
    logic [7:0]  bus_din = '0;
    logic [7:0]  bus_dout;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        program_stop;
    logic        tx_overflow;

    logic [7:0]  ram_mem [131072];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    int unsigned m_cnt = 0;
    int          we_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_dout = '0;

    bus_responder #(
        .TX_DEPTH_LOG2 (4),
        .RX_DEPTH_LOG2 (4),
        .FULL_MARGIN   (2)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .rdy_in         (rdy_in),
        .bus_a          (bus_a),
        .bus_wr         (bus_wr),
        .bus_din        (bus_din),
        .bus_dout       (bus_dout),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model with 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_a] <= ram_wdata;
            we_cnt <= we_cnt + 1;
        end
        ram_rdata <= ram_mem[ram_a];
    end

    // Reference cycle count: clock edges seen since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 0;
        else        m_cnt <= m_cnt + 1;
    end

    task automatic bus_op(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        bus_a = a; bus_wr = wr; bus_din = d; rdy_in = rdy;
    endtask

    task automatic idle();
        @(negedge clk);
        rdy_in = 1'b0; bus_wr = 1'b0;
    endtask

    // TX write with the UART stalled: model keeps up to TXD non-zero bytes.
    task automatic tx_write(input logic [7:0] d);
        bus_op(A_UART, 1'b1, d, 1'b1);
        idle();
        if (d != 8'h00 && tx_q.size() < TXD) tx_q.push_back(d);
    endtask

    task automatic rx_inject(input logic [7:0] d);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d;
        @(negedge clk);
        rx_valid = 1'b0;
        if (rx_q.size() < RXD) rx_q.push_back(d);
    endtask

    // Qualified RX read; the model returns the head or 0x00 when empty.
    task automatic rx_read_check(input string name);
        logic [7:0] e;
        e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        bus_op(A_UART, 1'b0, 8'h00, 1'b1);
        idle();
        #1;
        n_checks++;
        if (bus_dout !== e) begin
            n_fail++;
            $display("FAIL %s: bus_dout got %h expected %h", name, bus_dout, e);
        end
        exp_dout = e;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus_dout, tx_valid, io_buffer_full, program_stop, tx_overflow, ram_we} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_state: got dout=%h txv=%b full=%b stop=%b ovf=%b we=%b expected all zero",
                     bus_dout, tx_valid, io_buffer_full, program_stop, tx_overflow, ram_we);
        end
        rst_n = 1'b1;
        for (int i = 5; i < 8; i++) begin
            bus_op(32'h0003_0000 | 32'(i), 1'b0, 8'h00, 1'b1);
            idle();
            #1;
            n_checks++;
            if (bus_dout !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_snapshot_%0d: got %h expected 00", i, bus_dout);
            end
        end
    endtask

    task automatic test_ram();
        logic [31:0] a;
        logic [7:0]  d;
        int          w0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                a = 32'h0000_0010; d = 8'hA5;
            end else begin
                a = $urandom; a[17] = 1'b0; d = 8'($urandom);
            end
            w0 = we_cnt;
            bus_op(a, 1'b1, d, 1'b1);
            #1;
            n_checks++;
            if (ram_we !== 1'b1 || ram_a !== a[16:0] || ram_wdata !== d) begin
                n_fail++;
                $display("FAIL ram_write_%0d: got we=%b a=%h wd=%h expected 1 %h %h", i, ram_we, ram_a, ram_wdata, a[16:0], d);
            end
            idle();
            #1;
            n_checks++;
            if (we_cnt - w0 !== 1) begin
                n_fail++;
                $display("FAIL ram_we_pulse_%0d: got %0d pulses expected 1", i, we_cnt - w0);
            end
            bus_op(a, 1'b0, 8'h00, 1'b1);
            idle();
            #1;
            n_checks++;
            if (bus_dout !== d) begin
                n_fail++;
                $display("FAIL ram_read_%0d: got %h expected %h", i, bus_dout, d);
            end
            bus_op(a ^ 32'h1, 1'b1, ~d, 1'b1);
            idle();
            #1;
            n_checks++;
            if (bus_dout !== d) begin
                n_fail++;
                $display("FAIL ram_hold_%0d: got %h expected %h", i, bus_dout, d);
            end
            exp_dout = d;
        end
    endtask

    task automatic test_tx();
        logic [7:0] d;
        int         w0;
        int         guard;
        tx_ready = 1'b0;
        w0 = we_cnt;
        for (int i = 0; i < 14; i++) begin
            d = 8'($urandom_range(1, 255));
            tx_write(d);
            #1;
            n_checks++;
            if (io_buffer_full !== ((TXD - tx_q.size()) <= MARGIN) || tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
                n_fail++;
                $display("FAIL tx_fill_%0d: got full=%b valid=%b data=%h expected %b 1 %h",
                         i, io_buffer_full, tx_valid, tx_data, (TXD - tx_q.size()) <= MARGIN, tx_q[0]);
            end
        end
        tx_write(8'h00);
        bus_op(32'h0003_0002, 1'b1, 8'h77, 1'b1);
        idle();
        tx_write(8'($urandom_range(1, 255)));
        tx_write(8'($urandom_range(1, 255)));
        #1;
        n_checks++;
        if (tx_overflow !== 1'b0 || io_buffer_full !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_full_no_ovf: got ovf=%b full=%b expected 0 1", tx_overflow, io_buffer_full);
        end
        // Push and pop together on a full FIFO.
        d = 8'($urandom_range(1, 255));
        bus_op(A_UART, 1'b1, d, 1'b1);
        tx_ready = 1'b1;
        #1;
        n_checks++;
        if (tx_data !== tx_q[0]) begin
            n_fail++;
            $display("FAIL tx_full_head: got %h expected %h", tx_data, tx_q[0]);
        end
        void'(tx_q.pop_front());
        tx_q.push_back(d);
        idle();
        tx_ready = 1'b0;
        #1;
        n_checks++;
        if (tx_overflow !== 1'b0 || io_buffer_full !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_push_pop_full: got ovf=%b full=%b expected 0 1", tx_overflow, io_buffer_full);
        end
        tx_write(8'($urandom_range(1, 255)));
        #1;
        n_checks++;
        if (tx_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_overflow: got %b expected 1", tx_overflow);
        end
        n_checks++;
        if (we_cnt !== w0) begin
            n_fail++;
            $display("FAIL io_no_ram_we: got %0d pulses expected 0", we_cnt - w0);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        guard = 0;
        while (tx_q.size() > 0 && guard < 40) begin
            #1;
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== tx_q[0] || io_buffer_full !== ((TXD - tx_q.size()) <= MARGIN)) begin
                n_fail++;
                $display("FAIL tx_drain_%0d: got valid=%b data=%h full=%b expected 1 %h %b",
                         guard, tx_valid, tx_data, io_buffer_full, tx_q[0], (TXD - tx_q.size()) <= MARGIN);
            end
            void'(tx_q.pop_front());
            guard++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0 || guard !== TXD) begin
            n_fail++;
            $display("FAIL tx_drained: got valid=%b full=%b count=%0d expected 0 0 %0d", tx_valid, io_buffer_full, guard, TXD);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        int         n;
        logic [7:0] y;
        logic [7:0] e;
        rx_inject(8'h31);
        rx_inject(8'h32);
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) rx_inject(8'($urandom));
        for (int i = 0; i <= n + 2; i++) rx_read_check("rx_read");
        for (int i = 0; i < RXD + 1; i++) rx_inject(8'($urandom));
        // Read and receive in the same cycle while full.
        y = 8'($urandom);
        e = rx_q.pop_front();
        rx_q.push_back(y);
        bus_op(A_UART, 1'b0, 8'h00, 1'b1);
        rx_valid = 1'b1; rx_data = y;
        idle();
        rx_valid = 1'b0;
        #1;
        n_checks++;
        if (bus_dout !== e) begin
            n_fail++;
            $display("FAIL rx_push_pop_full: got %h expected %h", bus_dout, e);
        end
        for (int i = 0; i < RXD + 1; i++) rx_read_check("rx_full_read");
    endtask

    task automatic test_counter();
        logic [31:0] snap;
        int          guard;
        guard = 0;
        while (m_cnt < 32'h0000_FFF0 && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        bus_op(A_CLK, 1'b0, 8'h00, 1'b1);
        snap = m_cnt;
        idle();
        #1;
        n_checks++;
        if (bus_dout !== snap[7:0]) begin
            n_fail++;
            $display("FAIL clk_byte0: got %h expected %h", bus_dout, snap[7:0]);
        end
        guard = 0;
        while (m_cnt < 32'h0001_0008 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 5; i < 8; i++) begin
            bus_op(32'h0003_0000 | 32'(i), 1'b0, 8'h00, 1'b1);
            idle();
            #1;
            n_checks++;
            if (bus_dout !== 8'(snap >> (8 * (i - 4)))) begin
                n_fail++;
                $display("FAIL clk_byte%0d: got %h expected %h", i - 4, bus_dout, 8'(snap >> (8 * (i - 4))));
            end
        end
    endtask

    task automatic test_misc();
        rx_inject(8'hC3);
        bus_op(32'h0003_0001, 1'b0, 8'h00, 1'b1);
        idle();
        #1;
        n_checks++;
        if (bus_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL io_unmapped_read: got %h expected 00", bus_dout);
        end
        rx_read_check("rx_after_unmapped");
    endtask

    task automatic test_stop_and_unqualified();
        tx_ready = 1'b1;
        bus_op(A_CLK, 1'b1, 8'($urandom), 1'b1);
        idle();
        #1;
        n_checks++;
        if (program_stop !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL stop_write: got stop=%b valid=%b data=%h expected 1 1 00", program_stop, tx_valid, tx_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_drain: got valid=%b expected 0", tx_valid);
        end
        tx_ready = 1'b0;
        rx_inject(8'($urandom_range(1, 255)));
        bus_op(A_UART, 1'b0, 8'h00, 1'b0);
        idle();
        #1;
        n_checks++;
        if (bus_dout !== exp_dout) begin
            n_fail++;
            $display("FAIL unqualified_read: got %h expected %h", bus_dout, exp_dout);
        end
        rx_read_check("rx_after_unqualified");
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) tx_write(8'($urandom_range(1, 255)));
        rx_inject(8'h5A);
        rx_read_check("rx_before_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_dout, tx_valid, io_buffer_full, program_stop, tx_overflow} !== 12'h0) begin
            n_fail++;
            $display("FAIL async_reset: got dout=%h txv=%b full=%b stop=%b ovf=%b expected all zero",
                     bus_dout, tx_valid, io_buffer_full, program_stop, tx_overflow);
        end
        tx_q.delete();
        rx_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_op(A_CLK, 1'b0, 8'h00, 1'b1);
        e = m_cnt;
        idle();
        #1;
        n_checks++;
        if (bus_dout !== e[7:0]) begin
            n_fail++;
            $display("FAIL counter_after_reset: got %h expected %h", bus_dout, e[7:0]);
        end
        rx_read_check("rx_after_reset");
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx();
        test_rx();
        test_misc();
        test_stop_and_unqualified();
        test_counter();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
